// File: rtl/sccb_write_master.sv
// sccb_write_master: SCCB 3-phase write initiator (ID byte, sub-address, data) driving SIOC/SIOD.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   tick      in   1-cycle timing strobe from the SCCB clock generator
//   start     in   request one write, accepted only when idle
//   dev_addr  in   [7:0] ID byte, latched on accept
//   reg_addr  in   [7:0] sub-address, latched on accept
//   wr_data   in   [7:0] write data, latched on accept
//   busy      out  high from the cycle after accept until done pulses
//   done      out  1-cycle pulse at end of transaction
//   ack_err   out  sticky X-bit check result, valid with done
//   sioc      out  SCCB clock (push-pull)
//   siod_oe   out  1 = pull SIOD low, 0 = release
//   siod_in   in   sampled SIOD pad value
// Option: define SCCB_ACK_CHECK_EN to sample SIOD on each X bit and flag a high level in ack_err.
module sccb_write_master #(
    parameter int TICKS_PER_QUARTER = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       sioc,
    output logic       siod_oe,
    input  logic       siod_in
);
    typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;
    state_t      state, state_d;
    logic [7:0]  div;
    logic [1:0]  qc;
    logic [3:0]  bitc;
    logic [1:0]  bytec;
    logic [23:0] sh;
    logic        active, accept, q_stb, last_q, x_bit;
    logic        sioc_d, oe_d;
    assign active = state inside {START, BIT, STOP};
    assign accept = state == IDLE && start;
    assign q_stb  = active && tick && div == 8'(TICKS_PER_QUARTER - 1);
    assign last_q = q_stb && qc == 2'd3;
    assign x_bit  = bitc == 4'd8;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? START : IDLE;
            START:   state_d = last_q ? BIT : START;
            BIT:     state_d = (last_q && x_bit && bytec == 2'd2) ? STOP : BIT;
            STOP:    state_d = last_q ? DONE : STOP;
            default: state_d = IDLE;
        endcase
    end
    // Bits shift out of sh[23]; the X bit leaves the shifter untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div   <= '0;
            qc    <= '0;
            bitc  <= '0;
            bytec <= '0;
            sh    <= '0;
        end else if (accept) begin
            div   <= '0;
            qc    <= '0;
            bitc  <= '0;
            bytec <= '0;
            sh    <= {dev_addr, reg_addr, wr_data};
        end else if (active && tick) begin
            div <= q_stb ? 8'd0 : div + 8'd1;
            if (q_stb) qc <= qc + 2'd1;
            if (state == BIT && last_q) begin
                bitc <= x_bit ? 4'd0 : bitc + 4'd1;
                if (x_bit && bytec != 2'd2) bytec <= bytec + 2'd1;
                if (!x_bit) sh <= {sh[22:0], 1'b0};
            end
        end
    end
    // SIOD only moves together with or after SIOC falls, except the START/STOP edges.
    always_comb begin
        sioc_d = sioc;
        oe_d   = siod_oe;
        if (q_stb) begin
            case (state)
                START: begin
                    oe_d   = qc == 2'd0 ? 1'b1 : siod_oe;
                    sioc_d = qc == 2'd2 ? 1'b0 : sioc;
                end
                BIT: begin
                    oe_d   = qc == 2'd0 ? (!x_bit && !sh[23]) : siod_oe;
                    sioc_d = qc == 2'd0 ? 1'b0 : qc == 2'd2 ? 1'b1 : sioc;
                end
                STOP: begin
                    oe_d   = qc == 2'd0 ? 1'b1 : qc == 2'd2 ? 1'b0 : siod_oe;
                    sioc_d = qc == 2'd0 ? 1'b0 : qc == 2'd1 ? 1'b1 : sioc;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
        end else begin
            busy    <= state_d inside {START, BIT, STOP};
            done    <= state_d == DONE;
            sioc    <= sioc_d;
            siod_oe <= oe_d;
        end
    end
`ifdef SCCB_ACK_CHECK_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) ack_err <= 1'b0;
        else if (accept) ack_err <= 1'b0;
        else if (state == BIT && last_q && x_bit && siod_in) ack_err <= 1'b1;
`else
    logic unused_siod_in;
    assign unused_siod_in = siod_in;
    assign ack_err = 1'b0;
`endif
endmodule
